// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline:
// load-use stall, branch redirect, memory freeze, forwarding selects.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic        ex_reg_wr,
  input  logic        mem_reg_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_br_en,
  input  logic        ex_br_taken,
  input  logic        mem_busy,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        pc_load,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] FREEZE = 1'b1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [0:0] mode;
  logic       freeze;
  logic       br_hit;
  logic       lu_hit;
  logic       do_redirect;
  logic       do_stall;
  logic       do_advance;
  logic       ex_wr_ok;
  logic       mem_wr_ok;
  logic       rs1_ld;
  logic       rs2_ld;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  // Mode: frozen exactly while memory is busy; the first
  // non-busy cycle is already an ordinary RUN cycle.
  always_comb begin
    mode = RUN;
    if (mem_busy)
      mode = FREEZE;
  end

  assign freeze = (mode == FREEZE);

  // Raw hazard conditions from the stage inputs.
  always_comb begin
    ex_wr_ok  = ex_reg_wr & (ex_rd != 5'd0);
    mem_wr_ok = mem_reg_wr & (mem_rd != 5'd0);
    rs1_ld    = id_rs1_used & (id_rs1 == ex_rd);
    rs2_ld    = id_rs2_used & (id_rs2 == ex_rd);
    br_hit    = ex_br_en & ex_br_taken;
    lu_hit    = ex_mem_rd & ex_wr_ok
              & (rs1_ld | rs2_ld);
  end

  // Mutually exclusive actions in priority order:
  // freeze, redirect, load-use stall, advance.
  always_comb begin
    do_redirect = rst_n & ~freeze & br_hit;
    do_stall    = rst_n & ~freeze & ~br_hit & lu_hit;
    do_advance  = rst_n & ~freeze & ~br_hit & ~lu_hit;
  end

  // Same-cycle pipeline control.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    pc_load     = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (1'b1)
        freeze: begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          exmem_hold = 1'b1;
        end
        do_redirect: begin
          pc_load     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        do_stall: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand A source: younger EX result beats MEM/WB.
  always_comb begin
    fwd_a_d = FWD_RF;
    if (id_rs1_used) begin
      if (ex_wr_ok & ~ex_mem_rd
          & (id_rs1 == ex_rd))
        fwd_a_d = FWD_EX;
      else if (mem_wr_ok
               & (id_rs1 == mem_rd))
        fwd_a_d = FWD_WB;
    end
  end

  // Operand B source: same rule as operand A.
  always_comb begin
    fwd_b_d = FWD_RF;
    if (id_rs2_used) begin
      if (ex_wr_ok & ~ex_mem_rd
          & (id_rs2 == ex_rd))
        fwd_b_d = FWD_EX;
      else if (mem_wr_ok
               & (id_rs2 == mem_rd))
        fwd_b_d = FWD_WB;
    end
  end

  // Forward selects follow the instruction into EX;
  // a bubble carries no operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (do_advance) begin
      fwd_a_sel <= fwd_a_d;
      fwd_b_sel <= fwd_b_d;
    end else if (do_redirect | do_stall) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end
  end

  // Saturating load-use stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (do_stall && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 16'd1;
  end

  // Saturating taken-branch redirect counter.
  always_ff @(posedge clk) begin
    if (!rst_n)
      flush_cnt <= 16'd0;
    else if (do_redirect && flush_cnt != CNT_MAX)
      flush_cnt <= flush_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cases with literal
// expectations plus random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic [4:0]  ex_rd, mem_rd;
  logic        ex_reg_wr, mem_reg_wr;
  logic        ex_mem_rd;
  logic        ex_br_en, ex_br_taken;
  logic        mem_busy;
  logic        pc_hold, ifid_hold, ifid_flush;
  logic        idex_bubble, exmem_hold, pc_load;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // model state
  bit          started = 0;
  logic [1:0]  m_a, m_b;
  int          m_stall, m_flush;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_reg_wr(ex_reg_wr),
    .mem_reg_wr(mem_reg_wr),
    .ex_mem_rd(ex_mem_rd),
    .ex_br_en(ex_br_en),
    .ex_br_taken(ex_br_taken),
    .mem_busy(mem_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .exmem_hold(exmem_hold), .pc_load(pc_load),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // --- behavioural model -------------------------------
  function automatic bit load_use();
    if (!(ex_mem_rd && ex_reg_wr && ex_rd != 0))
      return 0;
    return (id_rs1_used && id_rs1 == ex_rd) ||
           (id_rs2_used && id_rs2 == ex_rd);
  endfunction

  function automatic logic [1:0] src_of(
    logic [4:0] rs, logic used);
    if (!used) return 2'b00;
    if (ex_reg_wr && ex_rd != 0 && rs == ex_rd
        && !ex_mem_rd) return 2'b01;
    if (mem_reg_wr && mem_rd != 0 && rs == mem_rd)
      return 2'b10;
    return 2'b00;
  endfunction

  // {pc_hold, ifid_hold, ifid_flush,
  //  idex_bubble, exmem_hold, pc_load}
  function automatic logic [5:0] exp_ctrl();
    if (!rst_n) return 6'b001100;
    if (mem_busy) return 6'b110010;
    if (ex_br_en && ex_br_taken) return 6'b001101;
    if (load_use()) return 6'b110100;
    return 6'b000000;
  endfunction

  // model update on each edge
  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1;
      m_a = 0; m_b = 0;
      m_stall = 0; m_flush = 0;
    end else if (started && !mem_busy) begin
      if (ex_br_en && ex_br_taken) begin
        m_a = 0; m_b = 0;
        if (m_flush < 65535) m_flush++;
      end else if (load_use()) begin
        m_a = 0; m_b = 0;
        if (m_stall < 65535) m_stall++;
      end else begin
        m_a = src_of(id_rs1, id_rs1_used);
        m_b = src_of(id_rs2, id_rs2_used);
      end
    end
  end

  // compare every cycle once reset has been seen
  always @(negedge clk) begin
    if (started) begin
      check("ctrl", {pc_hold, ifid_hold, ifid_flush,
                     idex_bubble, exmem_hold, pc_load},
            exp_ctrl());
      check("fwd_a", fwd_a_sel, m_a);
      check("fwd_b", fwd_b_sel, m_b);
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
    end
  end

  // --- stimulus helpers --------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = 0; mem_rd = 0;
    ex_reg_wr = 0; mem_reg_wr = 0;
    ex_mem_rd = 0;
    ex_br_en = 0; ex_br_taken = 0;
    mem_busy = 0;
  endtask

  function automatic int ctrl_now();
    return {pc_hold, ifid_hold, ifid_flush,
            idex_bubble, exmem_hold, pc_load};
  endfunction

  task automatic alu_case(string name,
    bit ex_hit, bit mem_hit, logic [4:0] rd,
    logic [1:0] exp);
    idle();
    id_rs1 = 5; id_rs1_used = 1;
    id_rs2 = 2; id_rs2_used = 1;
    if (ex_hit) begin ex_rd = rd; ex_reg_wr = 1; end
    if (mem_hit) begin mem_rd = rd; mem_reg_wr = 1; end
    cyc();
    idle();
    settle();
    check(name, fwd_a_sel, exp);
    check({name, "_b"}, fwd_b_sel, 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    cyc();
    settle();
    check("rst_ctrl", ctrl_now(), 6'b001100);
    check("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
    check("rst_cnt", {stall_cnt, flush_cnt}, 0);
    rst_n = 1;

    // independent stream
    id_rs1 = 2; id_rs2 = 3;
    id_rs1_used = 1; id_rs2_used = 1;
    ex_rd = 1; ex_reg_wr = 1;
    mem_rd = 4; mem_reg_wr = 1;
    settle();
    check("indep_ctrl", ctrl_now(), 0);
    cyc();
    id_rs1 = 5; id_rs2 = 6; ex_rd = 4;
    mem_rd = 1;
    settle();
    check("indep_ctrl2", ctrl_now(), 0);
    check("indep_fwd", {fwd_a_sel, fwd_b_sel}, 0);
    cyc();
    settle();
    check("indep_fwd2", {fwd_a_sel, fwd_b_sel}, 0);
    check("indep_cnt", {stall_cnt, flush_cnt}, 0);

    // ALU chain on x5
    alu_case("alu_ex", 1, 0, 5, 2'b01);
    alu_case("alu_mem", 0, 1, 5, 2'b10);
    alu_case("alu_both", 1, 1, 5, 2'b01);
    alu_case("alu_x0", 1, 1, 0, 2'b00);

    // load-use: ld x7 in EX, add x8,x7,x9 in ID
    idle();
    ex_rd = 7; ex_reg_wr = 1; ex_mem_rd = 1;
    id_rs1 = 7; id_rs2 = 9;
    id_rs1_used = 1; id_rs2_used = 1;
    settle();
    check("lu_ctrl", ctrl_now(), 6'b110100);
    cyc();
    ex_rd = 0; ex_reg_wr = 0; ex_mem_rd = 0;
    mem_rd = 7; mem_reg_wr = 1;
    settle();
    check("lu_ctrl2", ctrl_now(), 0);
    check("lu_fwd0", fwd_a_sel, 2'b00);
    check("lu_stall", stall_cnt, 1);
    cyc();
    idle();
    settle();
    check("lu_fwd_a", fwd_a_sel, 2'b10);

    // taken branch with a simultaneous load-use
    ex_rd = 7; ex_reg_wr = 1; ex_mem_rd = 1;
    id_rs1 = 7; id_rs1_used = 1;
    ex_br_en = 1; ex_br_taken = 1;
    settle();
    check("br_ctrl", ctrl_now(), 6'b001101);
    cyc();
    idle();
    settle();
    check("br_flush", flush_cnt, 1);
    check("br_stall", stall_cnt, 1);

    // freeze with a pending taken branch
    mem_busy = 1;
    ex_br_en = 1; ex_br_taken = 1;
    id_rs1 = 3; id_rs1_used = 1;
    mem_rd = 3; mem_reg_wr = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("frz_ctrl", ctrl_now(), 6'b110010);
      cyc();
    end
    mem_busy = 0;
    settle();
    check("frz_flush", flush_cnt, 1);
    check("frz_fwd", fwd_a_sel, 2'b00);
    check("frz_exit", ctrl_now(), 6'b001101);
    cyc();
    idle();
    settle();
    check("frz_once", pc_load, 0);
    check("frz_flush2", flush_cnt, 2);

    // random traffic, rare mid-run resets
    for (int n = 0; n < 3000; n++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom);
      id_rs2_used = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      ex_reg_wr = 1'($urandom);
      mem_reg_wr = 1'($urandom);
      ex_mem_rd = ($urandom_range(0, 3) == 0);
      ex_br_en = ($urandom_range(0, 5) == 0);
      ex_br_taken = 1'($urandom);
      mem_busy = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end

    // saturation
    idle();
    rst_n = 0;
    cyc();
    rst_n = 1;
    settle();
    check("sat_start", stall_cnt, 0);
    ex_rd = 9; ex_reg_wr = 1; ex_mem_rd = 1;
    id_rs2 = 9; id_rs2_used = 1;
    for (int n = 0; n < 65537; n++) cyc();
    idle();
    settle();
    check("sat_stall", stall_cnt, 16'hFFFF);
    check("sat_flush", flush_cnt, 0);

    // reset clears everything
    id_rs1 = 4; id_rs1_used = 1;
    mem_rd = 4; mem_reg_wr = 1;
    cyc();
    rst_n = 0;
    settle();
    check("pre_rst_fwd", fwd_a_sel, 2'b10);
    cyc();
    settle();
    check("post_rst_cnt", {stall_cnt, flush_cnt}, 0);
    check("post_rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
    rst_n = 1;
    idle();
    settle();
    check("post_rst_run", ctrl_now(), 0);
    cyc();
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
